// File: rtl/stq_fwd_sel_if.sv
// Store-to-load forwarding select bus.
// Groups the check request coming from the store-buffer check port with the
// registered forwarding result going back to the load pipeline.
//   chk_en/chk_match/chk_partial/chk_pos/head/full/chk_tag : request side
//   out_en/out_hit/out_replay/out_idx/out_tag             : result side
// slave  = selector (consumes requests, produces results)
// master = load pipeline / requester
interface stq_fwd_sel_if #(
   parameter int BUF_COUNT = 32,
   parameter int PTR_W     = 5,
   parameter int TAG_W     = 9
);
   logic                 chk_en;
   logic [BUF_COUNT-1:0] chk_match;
   logic [BUF_COUNT-1:0] chk_partial;
   logic [PTR_W-1:0]     chk_pos;
   logic [PTR_W-1:0]     head;
   logic                 full;
   logic [TAG_W-1:0]     chk_tag;

   logic                 out_en;
   logic                 out_hit;
   logic                 out_replay;
   logic [PTR_W-1:0]     out_idx;
   logic [TAG_W-1:0]     out_tag;

   modport slave (
      input  chk_en, chk_match, chk_partial, chk_pos, head, full, chk_tag,
      output out_en, out_hit, out_replay, out_idx, out_tag
   );

   modport master (
      output chk_en, chk_match, chk_partial, chk_pos, head, full, chk_tag,
      input  out_en, out_hit, out_replay, out_idx, out_tag
   );
endinterface

// File: rtl/stq_fwd_sel.sv
// Store-queue forwarding selector.
// Two-stage pipeline: stage 1 masks the per-entry match/partial vectors with
// the circular window [head, chk_pos) and latches them; stage 2 picks the
// youngest windowed entry (searching backward from chk_pos-1) and registers
// the forward/replay decision.
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   stall      hold both pipeline stages
//   excpt      flush in-flight checks and clear replay_cnt
//   bus        stq_fwd_sel_if.slave request/result bundle
//   replay_cnt saturating count of replay results
module stq_fwd_sel #(
   parameter int BUF_COUNT = 32,
   parameter int PTR_W     = 5,
   parameter int TAG_W     = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         stall,
   input  logic         excpt,
   stq_fwd_sel_if.slave bus,
   output logic [3:0]   replay_cnt
);

   // ---------------- window mask ----------------
   // An entry is in the window when its distance from head is below the
   // window length. head==chk_pos is ambiguous: full decides empty vs all.
   logic [BUF_COUNT-1:0] win_mask;
   logic [PTR_W-1:0]     win_len;
   logic                 win_all;

   assign win_len = bus.chk_pos - bus.head;
   assign win_all = bus.full && (bus.chk_pos == bus.head);

   genvar gi;
   generate
      for (gi = 0; gi < BUF_COUNT; gi++) begin : g_win
         logic [PTR_W-1:0] ofs;
         assign ofs          = PTR_W'(gi) - bus.head;
         assign win_mask[gi] = win_all || (ofs < win_len);
      end
   endgenerate

   // ---------------- stage 1 registers ----------------
   logic                 s1_vld_reg;
   logic [TAG_W-1:0]     s1_tag_reg;
   logic [PTR_W-1:0]     s1_pos_reg;
   logic [BUF_COUNT-1:0] s1_match_reg;
   logic [BUF_COUNT-1:0] s1_part_reg;

   // ---------------- stage 2 select ----------------
   logic [BUF_COUNT-1:0] s1_any;
   logic                 sel_found;
   logic [PTR_W-1:0]     sel_idx;
   logic [PTR_W-1:0]     cand;

   assign s1_any = s1_match_reg | s1_part_reg;

   // Priority search from the youngest older store (pos-1) backward. The
   // pointer arithmetic wraps naturally; the last candidate (k=BUF_COUNT)
   // is pos itself, which is only windowed in the full case.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= BUF_COUNT; k++) begin
         cand = s1_pos_reg - PTR_W'(k);
         if (!sel_found && s1_any[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   logic             hit_next;
   logic             rep_next;
   logic [PTR_W-1:0] idx_next;

   // Partial overlap always forces a replay, even if the full match bit is
   // also set; a found entry without partial must therefore be a match.
   always_comb begin
      hit_next = 1'b0;
      rep_next = 1'b0;
      idx_next = '0;
      if (s1_vld_reg && sel_found) begin
         if (s1_part_reg[sel_idx]) rep_next = 1'b1;
         else                      hit_next = 1'b1;
         idx_next = sel_idx;
      end
   end

   // ---------------- pipeline registers ----------------
   logic             out_en_reg;
   logic             out_hit_reg;
   logic             out_rep_reg;
   logic [PTR_W-1:0] out_idx_reg;
   logic [TAG_W-1:0] out_tag_reg;
   logic [3:0]       replay_cnt_reg;

   // excpt beats stall so a flush is never lost while the pipe is held.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_vld_reg   <= 1'b0;
         s1_tag_reg   <= '0;
         s1_pos_reg   <= '0;
         s1_match_reg <= '0;
         s1_part_reg  <= '0;
         out_en_reg   <= 1'b0;
         out_hit_reg  <= 1'b0;
         out_rep_reg  <= 1'b0;
         out_idx_reg  <= '0;
         out_tag_reg  <= '0;
      end else if (excpt) begin
         s1_vld_reg  <= 1'b0;
         out_en_reg  <= 1'b0;
         out_hit_reg <= 1'b0;
         out_rep_reg <= 1'b0;
      end else if (!stall) begin
         s1_vld_reg   <= bus.chk_en;
         s1_tag_reg   <= bus.chk_tag;
         s1_pos_reg   <= bus.chk_pos;
         s1_match_reg <= bus.chk_match & win_mask;
         s1_part_reg  <= bus.chk_partial & win_mask;
         out_en_reg   <= s1_vld_reg;
         out_hit_reg  <= hit_next;
         out_rep_reg  <= rep_next;
         out_idx_reg  <= idx_next;
         out_tag_reg  <= s1_tag_reg;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         replay_cnt_reg <= '0;
      end else if (excpt) begin
         replay_cnt_reg <= '0;
      end else if (out_en_reg && out_rep_reg && (replay_cnt_reg != 4'hF)) begin
         replay_cnt_reg <= replay_cnt_reg + 4'd1;
      end
   end

   assign bus.out_en     = out_en_reg;
   assign bus.out_hit    = out_hit_reg;
   assign bus.out_replay = out_rep_reg;
   assign bus.out_idx    = out_idx_reg;
   assign bus.out_tag    = out_tag_reg;
   assign replay_cnt     = replay_cnt_reg;

endmodule

// File: doc/stq_fwd_sel.md
STQ_FWD_SEL -- requirements
Module: stq_fwd_sel

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 SHALL have parameter BUF_COUNT, default 32, store-queue entries per row.
REQ-003 SHALL have parameter PTR_W, default 5, store-queue pointer width (log2 BUF_COUNT).
REQ-004 SHALL have parameter TAG_W, default 9, load tag width.
REQ-005 Ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- stall  in  1  hold both pipeline stages
- excpt  in  1  flush: drop all in-flight checks
- chk_en  in  1  check request valid this cycle
- chk_match  in  BUF_COUNT  per-entry full-forward match from the store-buffer check port
- chk_partial  in  BUF_COUNT  per-entry partial/unresolved overlap from the same port
- chk_pos  in  PTR_W  load's store-queue tail snapshot; entries older than the load lie below it, circularly
- head  in  PTR_W  oldest live store-queue entry
- full  in  1  queue full, so head==chk_pos means all entries live
- chk_tag  in  TAG_W  load tag carried with the request
- out_en  out  1  result valid
- out_hit  out  1  forward from out_idx
- out_replay  out  1  load must replay
- out_idx  out  PTR_W  selected entry
- out_tag  out  TAG_W  tag of the result
- replay_cnt  out  4  saturating replay counter

Function
REQ-006 Window SHALL be entries head, head+1, ..., chk_pos-1 mod BUF_COUNT; head==chk_pos with full=0 gives an empty window; with full=1 all entries are in the window.
REQ-007 Stage 1 SHALL latch chk_en, chk_tag, chk_pos, (chk_match & window) and (chk_partial & window) when stall=0.
REQ-008 Stage 2 SHALL select the youngest windowed entry, the first found searching backward from chk_pos-1 with wrap to BUF_COUNT-1, whose match or partial bit is set, and SHALL register the result when stall=0.
REQ-009 Selected entry with partial=1 SHALL give out_replay=1, out_hit=0, regardless of its match bit.
REQ-010 Selected entry with match=1, partial=0 SHALL give out_hit=1, out_replay=0, out_idx = entry index.
REQ-011 No entry selected SHALL give out_hit=0, out_replay=0, out_idx=0; out_en still follows the request.
REQ-012 out_en SHALL assert exactly 2 cycles after an accepted chk_en, for one cycle, with no stalls.
REQ-013 With stall=1, both stage registers and outputs SHALL hold; chk_en during stall SHALL be ignored.
REQ-014 excpt=1 SHALL clear both stage valid bits next edge, overriding stall; out_en=0 the following cycle; chk_en in the same cycle SHALL be dropped.
REQ-015 out_hit and out_replay SHALL never both be 1; both SHALL be 0 when out_en=0.
REQ-016 replay_cnt SHALL increment on each cycle with out_en & out_replay, saturate at 15, and clear on excpt; clear wins over increment.
REQ-017 Back-to-back requests SHALL be accepted every non-stalled cycle, fully pipelined.

Reset
REQ-018 rst=0 SHALL asynchronously clear stage valids, out_en, out_hit, out_replay, out_idx, out_tag and replay_cnt to 0.
REQ-019 Reset asserted mid-operation SHALL discard all in-flight checks; the first result after release comes from a request accepted after release.

Verification
REQ-020 head=2, chk_pos=6, match bits 3 and 5 set -> 2 cycles later out_en=1, out_hit=1, out_idx=5.
REQ-021 head=30, chk_pos=1, match bit 31, partial bit 0 -> out_replay=1, out_idx=0, replay_cnt increments to 1.
REQ-022 head=chk_pos=7, full=0, all match bits set -> out_en=1, out_hit=0, out_replay=0; same with full=1 -> out_hit=1, out_idx=6.
REQ-023 Request then stall=1 for 3 cycles -> out_en rises only after stall drops, with the tag unchanged.
REQ-024 excpt=1 one cycle after a request -> no out_en; 16 consecutive replays -> replay_cnt=15, then excpt -> 0.
REQ-025 rst=0 asserted with 2 checks in flight -> outputs 0 immediately, no out_en after release.
